// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed 32x32 multiply / 32/32 divide with the
// HI/LO register pair. A three-state FSM (IDLE -> CALC x32 -> FIX) walks a
// shift-add multiplier or a restoring divider one bit per cycle, then commits
// sign-corrected results to HI/LO. Stall holds EX while a dependent op waits.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  Op,
    input  logic        Valid,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Result,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Stall,
    output logic        Done
);

    localparam logic [3:0] OP_MFHI = 4'h3;
    localparam logic [3:0] OP_MFLO = 4'h4;
    localparam logic [3:0] OP_MULT = 4'h5;
    localparam logic [3:0] OP_DIV  = 4'h8;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state, state_nxt;
    logic        is_div;      // latched operation kind
    logic        sign_a;      // latched sign of dividend / multiplicand
    logic        sign_b;      // latched sign of divisor / multiplier
    logic [31:0] a_mag;       // |A|
    logic [31:0] b_mag;       // |B|
    logic [63:0] acc;         // mult: running product; div: {remainder, quotient}
    logic [4:0]  cnt;         // CALC step index

    logic        is_md_op;
    logic        issue;

    // one-step datapath values
    logic [63:0] mul_addend;
    logic [32:0] div_tmp;
    logic        div_ge;
    logic [32:0] div_rem;

    // sign-corrected commit values
    logic [63:0] prod_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] a_orig;

    assign is_md_op = (Op == OP_MULT) || (Op == OP_DIV);
    assign issue    = Valid && is_md_op && (state == IDLE);

    // Stall only for instructions that touch HI/LO or the unit itself
    assign Stall  = Valid && Busy &&
                    (is_md_op || (Op == OP_MFHI) || (Op == OP_MFLO));
    assign Result = (Op == OP_MFHI) ? HI : LO;

    // FSM next state and status outputs
    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            IDLE: begin
                if (issue) state_nxt = CALC;
            end
            CALC: begin
                Busy = 1'b1;
                if (cnt == 5'd31) state_nxt = FIX;
            end
            FIX: begin
                Busy      = 1'b1;
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-cycle arithmetic step: multiplier bit cnt (LSB first), dividend bit
    // 31-cnt (MSB first) shifted into the partial remainder.
    always_comb begin
        mul_addend = b_mag[cnt] ? ({32'b0, a_mag} << cnt) : 64'b0;
        div_tmp    = {acc[63:32], a_mag[5'd31 - cnt]};
        div_ge     = div_tmp >= {1'b0, b_mag};
        div_rem    = div_ge ? (div_tmp - {1'b0, b_mag}) : div_tmp;
    end

    // Sign correction; the original A is rebuilt from its sign and magnitude
    // so the divide-by-zero case can return it without an extra register.
    always_comb begin
        prod_s = (sign_a ^ sign_b) ? -acc : acc;
        quot_s = (sign_a ^ sign_b) ? -acc[31:0] : acc[31:0];
        rem_s  = sign_a ? -acc[63:32] : acc[63:32];
        a_orig = sign_a ? -a_mag : a_mag;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand latch, iteration and HI/LO commit
    always_ff @(posedge clk) begin
        if (rst) begin
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            a_mag  <= 32'b0;
            b_mag  <= 32'b0;
            acc    <= 64'b0;
            cnt    <= 5'b0;
            HI     <= 32'b0;
            LO     <= 32'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        is_div <= (Op == OP_DIV);
                        sign_a <= A[31];
                        sign_b <= B[31];
                        a_mag  <= A[31] ? -A : A;
                        b_mag  <= B[31] ? -B : B;
                        acc    <= 64'b0;
                        cnt    <= 5'b0;
                    end
                end
                CALC: begin
                    if (is_div) acc <= {div_rem[31:0], acc[30:0], div_ge};
                    else        acc <= acc + mul_addend;
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    if (!is_div) begin
                        HI <= prod_s[63:32];
                        LO <= prod_s[31:0];
                    end else if (b_mag == 32'b0) begin
                        HI <= a_orig;
                        LO <= 32'hFFFF_FFFF;
                    end else begin
                        HI <= rem_s;
                        LO <= quot_s;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases from the block's
// corner list plus randomized mult/div compared against a signed-arithmetic
// reference model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  Op;
    logic        Valid;
    logic [31:0] A, B;
    logic [31:0] Result, HI, LO;
    logic        Busy, Stall, Done;

    int checks = 0;
    int errors = 0;
    logic [31:0] prev_hi, prev_lo;

    muldiv_sequencer dut (
        .clk(clk), .rst(rst), .Op(Op), .Valid(Valid), .A(A), .B(B),
        .Result(Result), .HI(HI), .LO(LO), .Busy(Busy), .Stall(Stall),
        .Done(Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: {HI,LO} from plain signed 64-bit arithmetic
    function automatic logic [63:0] model(input logic dv, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, q, r, p;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (!dv) begin
            p = la * lb;
            return p;
        end
        if (b == 32'b0) return {a, 32'hFFFF_FFFF};
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full issue-to-commit transaction with timing checks
    task automatic run_op(input logic dv, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
        tick();
        Valid = 1'b1; Op = dv ? 4'h8 : 4'h5; A = a; B = b;
        tick();
        Valid = 1'b0; Op = 4'h0; A = $urandom; B = $urandom;
        for (int k = 1; k <= 33; k++) begin
            chk("busy_calc", Busy, 1);
            chk("done_pulse", Done, k == 33);
            if (k == 33) chk("hilo_hold", {HI, LO}, {prev_hi, prev_lo});
            tick();
        end
        chk("busy_end", Busy, 0);
        chk("done_end", Done, 0);
        chk("hi", HI, ehi);
        chk("lo", LO, elo);
        Op = 4'h3; #1;
        chk("result_mfhi", Result, ehi);
        Op = 4'h4; #1;
        chk("result_mflo", Result, elo);
        Op = 4'h0;
        prev_hi = ehi; prev_lo = elo;
    endtask

    initial begin
        logic [63:0] m;
        logic [31:0] ra, rb;
        logic        rdv;

        rst = 1'b1; Valid = 1'b1; Op = 4'h5; A = 32'd9; B = 32'd9;
        tick(); tick();
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_stall", Stall, 0);
        rst = 1'b0; Valid = 1'b0; Op = 4'h0;
        prev_hi = 32'h0; prev_lo = 32'h0;

        // directed corner cases
        run_op(0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op(1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        run_op(1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_op(1, 32'hFFFF_FFF6, 32'd0, 32'hFFFF_FFF6, 32'hFFFF_FFFF);
        run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op(0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);

        // dependent mflo held in EX from cycle 1
        tick();
        Valid = 1'b1; Op = 4'h5; A = 32'd3; B = 32'd4;
        tick();
        Op = 4'h4;
        for (int k = 1; k <= 33; k++) begin
            chk("stall_mflo", Stall, 1);
            tick();
        end
        chk("stall_mflo_drop", Stall, 0);
        chk("mflo_result", Result, 32'd12);
        chk("mflo_busy", Busy, 0);
        Valid = 1'b0; Op = 4'h0;
        prev_hi = 32'd0; prev_lo = 32'd12;

        // unrelated ALU op mid-operation never stalls
        tick();
        Valid = 1'b1; Op = 4'h5; A = 32'd5; B = 32'd6;
        tick();
        Valid = 1'b0; Op = 4'h0;
        for (int k = 1; k <= 33; k++) begin
            if (k == 10) begin
                Valid = 1'b1; Op = 4'h2; #1;
                chk("stall_add", Stall, 0);
                Valid = 1'b0; Op = 4'h0;
            end
            tick();
        end
        chk("add_lo", LO, 32'd30);
        prev_hi = 32'd0; prev_lo = 32'd30;

        // back-to-back: div presented at cycle 5 while the mult runs
        m = model(0, 32'h0001_2345, 32'hFFFF_6789);
        tick();
        Valid = 1'b1; Op = 4'h5; A = 32'h0001_2345; B = 32'hFFFF_6789;
        tick();
        Valid = 1'b0; Op = 4'h0;
        for (int k = 1; k <= 33; k++) begin
            if (k == 5) begin Valid = 1'b1; Op = 4'h8; A = 32'd1000; B = 32'd7; end
            if (k >= 5) begin #1; chk("stall_b2b", Stall, 1); end
            tick();
        end
        chk("b2b_stall_drop", Stall, 0);
        chk("b2b_busy_gap", Busy, 0);
        chk("b2b_first", {HI, LO}, m);
        tick();
        Valid = 1'b0; Op = 4'h0;
        for (int k = 1; k <= 33; k++) begin
            chk("b2b_busy", Busy, 1);
            chk("b2b_done", Done, k == 33);
            if (k == 33) chk("b2b_hold", {HI, LO}, m);
            tick();
        end
        chk("b2b_second", {HI, LO}, {32'd6, 32'd142});
        prev_hi = 32'd6; prev_lo = 32'd142;

        // reset mid-operation discards the partial result
        tick();
        Valid = 1'b1; Op = 4'h5; A = 32'd100; B = 32'd100;
        tick();
        Valid = 1'b0; Op = 4'h0;
        for (int k = 1; k < 10; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_hilo", {HI, LO}, 64'd0);
        chk("rst_mid_busy", Busy, 0);
        for (int k = 0; k < 40; k++) begin
            if (Done !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
                chk("rst_no_commit", {31'd0, Done, HI, LO}, 64'd0);
            tick();
        end
        chk("rst_idle_done", Done, 0);
        prev_hi = 32'd0; prev_lo = 32'd0;
        run_op(0, 32'd100, 32'd100, 32'd0, 32'd10000);

        // randomized against the reference model
        for (int i = 0; i < 24; i++) begin
            rdv = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'($urandom_range(0, 15)) - 32'd8;
                1: ra = 32'($urandom_range(0, 255));
                2: rb = 32'b0;
                default: ;
            endcase
            m = model(rdv, ra, rb);
            run_op(rdv, ra, rb, m[63:32], m[31:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
